// File: rtl/sram_responder_dp_if.sv
// Instruction and data SRAM bus bundle between the CPU core and its memory.
// master = CPU side, slave = memory responder side.
interface sram_responder_dp_if;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;

    modport master (
        output inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
        output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
        input  inst_sram_rdata, data_sram_rdata
    );

    modport slave (
        input  inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
        input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
        output inst_sram_rdata, data_sram_rdata
    );
endinterface

// File: rtl/sram_responder_dp.sv
// Dual-port SRAM responder: read-only instruction port, byte-write data port.
// Define SRAM_PERF_CNT_EN to build the saturating access counters.
module sram_responder_dp #(
    parameter int ADDR_W    = 16,
    parameter     INIT_FILE = ""
) (
    input  logic                 clk,
    input  logic                 reset,
    sram_responder_dp_if.slave   bus,
    input  logic                 cnt_clr,
    output logic [31:0]          inst_rd_cnt,
    output logic [31:0]          data_rd_cnt,
    output logic [31:0]          data_wr_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0]       mem [0:DEPTH-1];
    logic [ADDR_W-1:0] inst_idx;
    logic [ADDR_W-1:0] data_idx;
    logic              data_rd;
    logic              data_wr;
    logic [31:0]       inst_q;
    logic [31:0]       data_q;

    assign inst_idx = bus.inst_sram_addr[ADDR_W+1:2];
    assign data_idx = bus.data_sram_addr[ADDR_W+1:2];
    assign data_rd  = bus.data_sram_en && (bus.data_sram_wen == 4'b0000);
    assign data_wr  = bus.data_sram_en && (bus.data_sram_wen != 4'b0000);

    // Byte-lane array writes; nothing commits while reset is high.
    always_ff @(posedge clk) begin
        if (!reset && data_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.data_sram_wen[b]) begin
                    mem[data_idx][8*b +: 8] <= bus.data_sram_wdata[8*b +: 8];
                end
            end
        end
    end

    // Registered read data; sampling the pre-edge array gives read-first collisions.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inst_q <= 32'h0;
            data_q <= 32'h0;
        end else begin
            if (bus.inst_sram_en) begin
                inst_q <= mem[inst_idx];
            end
            if (data_rd) begin
                data_q <= mem[data_idx];
            end
        end
    end

    assign bus.inst_sram_rdata = inst_q;
    assign bus.data_sram_rdata = data_q;

`ifdef SRAM_PERF_CNT_EN
    logic [31:0] inst_cnt_q;
    logic [31:0] drd_cnt_q;
    logic [31:0] dwr_cnt_q;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    // Saturating access counters; a clear beats a same-cycle increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inst_cnt_q <= 32'h0;
            drd_cnt_q  <= 32'h0;
            dwr_cnt_q  <= 32'h0;
        end else if (cnt_clr) begin
            inst_cnt_q <= 32'h0;
            drd_cnt_q  <= 32'h0;
            dwr_cnt_q  <= 32'h0;
        end else begin
            if (bus.inst_sram_en) inst_cnt_q <= sat_inc(inst_cnt_q);
            if (data_rd)          drd_cnt_q  <= sat_inc(drd_cnt_q);
            if (data_wr)          dwr_cnt_q  <= sat_inc(dwr_cnt_q);
        end
    end

    assign inst_rd_cnt = inst_cnt_q;
    assign data_rd_cnt = drd_cnt_q;
    assign data_wr_cnt = dwr_cnt_q;

    logic unused_bits;
    assign unused_bits = ^{bus.inst_sram_wen, bus.inst_sram_wdata,
                           bus.inst_sram_addr[31:ADDR_W+2],
                           bus.inst_sram_addr[1:0],
                           bus.data_sram_addr[31:ADDR_W+2],
                           bus.data_sram_addr[1:0]};
`else
    assign inst_rd_cnt = 32'h0;
    assign data_rd_cnt = 32'h0;
    assign data_wr_cnt = 32'h0;

    logic unused_bits;
    assign unused_bits = ^{bus.inst_sram_wen, bus.inst_sram_wdata,
                           bus.inst_sram_addr[31:ADDR_W+2],
                           bus.inst_sram_addr[1:0],
                           bus.data_sram_addr[31:ADDR_W+2],
                           bus.data_sram_addr[1:0], cnt_clr};
`endif

endmodule

// File: tb/tb_sram_responder_dp.sv
// Directed self-checking bench for sram_responder_dp.
// Counter checks follow SRAM_PERF_CNT_EN.
module tb_sram_responder_dp;

    logic        clk;
    logic        reset;
    logic        cnt_clr;
    logic [31:0] inst_rd_cnt;
    logic [31:0] data_rd_cnt;
    logic [31:0] data_wr_cnt;
    logic [31:0] cnt2_unused_i;
    logic [31:0] cnt2_unused_r;
    logic [31:0] cnt2_unused_w;

    int checks;
    int errors;

    sram_responder_dp_if bus ();
    sram_responder_dp_if bus2 ();

    sram_responder_dp dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .cnt_clr     (cnt_clr),
        .inst_rd_cnt (inst_rd_cnt),
        .data_rd_cnt (data_rd_cnt),
        .data_wr_cnt (data_wr_cnt)
    );

    sram_responder_dp #(.ADDR_W(4)) dut2 (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus2),
        .cnt_clr     (cnt_clr),
        .inst_rd_cnt (cnt2_unused_i),
        .data_rd_cnt (cnt2_unused_r),
        .data_wr_cnt (cnt2_unused_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.inst_sram_en  = 1'b0;
        bus.data_sram_en  = 1'b0;
        bus.data_sram_wen = 4'b0000;
        bus2.inst_sram_en  = 1'b0;
        bus2.data_sram_en  = 1'b0;
        bus2.data_sram_wen = 4'b0000;
        cnt_clr = 1'b0;
    endtask

    task automatic dwrite(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] we);
        bus.data_sram_en    = 1'b1;
        bus.data_sram_wen   = we;
        bus.data_sram_addr  = a;
        bus.data_sram_wdata = d;
        step();
        idle();
    endtask

    task automatic dread(input logic [31:0] a);
        bus.data_sram_en   = 1'b1;
        bus.data_sram_wen  = 4'b0000;
        bus.data_sram_addr = a;
        step();
        idle();
    endtask

    task automatic iread(input logic [31:0] a);
        bus.inst_sram_en   = 1'b1;
        bus.inst_sram_addr = a;
        step();
        idle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.inst_sram_wen   = 4'b1111;
        bus.inst_sram_wdata = 32'hFFFFFFFF;
        bus.inst_sram_addr  = 32'h0;
        bus.data_sram_addr  = 32'h0;
        bus.data_sram_wdata = 32'h0;
        bus2.inst_sram_wen   = 4'b0000;
        bus2.inst_sram_wdata = 32'h0;
        bus2.inst_sram_addr  = 32'h0;
        bus2.data_sram_addr  = 32'h0;
        bus2.data_sram_wdata = 32'h0;
        idle();
        step();
        step();
        check("rst_inst_rdata", bus.inst_sram_rdata, 32'h0);
        check("rst_data_rdata", bus.data_sram_rdata, 32'h0);
        check("rst_inst_cnt", inst_rd_cnt, 32'h0);
        check("rst_dwr_cnt", data_wr_cnt, 32'h0);
        reset = 1'b0;
        step();

        dwrite(32'h100, 32'hDEADBEEF, 4'b1111);
        dwrite(32'h100, 32'h000000AA, 4'b0001);
        dread(32'h100);
        check("byte_merge", bus.data_sram_rdata, 32'hDEADBEAA);
        dwrite(32'h102, 32'h77000000, 4'b1000);
        dread(32'h100);
        check("byte_lane3", bus.data_sram_rdata, 32'h77ADBEAA);
        dwrite(32'h100, 32'hDE000000, 4'b1000);
        dread(32'h100);
        check("byte_restore", bus.data_sram_rdata, 32'hDEADBEAA);

        dwrite(32'h300, 32'h12345678, 4'b1111);
        check("hold_wr", bus.data_sram_rdata, 32'hDEADBEAA);
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_idle", bus.data_sram_rdata, 32'hDEADBEAA);
        end
        dread(32'h300);
        check("rd_300", bus.data_sram_rdata, 32'h12345678);

        dwrite(32'h200, 32'h11111111, 4'b1111);
        bus.inst_sram_en    = 1'b1;
        bus.inst_sram_addr  = 32'h200;
        bus.data_sram_en    = 1'b1;
        bus.data_sram_wen   = 4'b1111;
        bus.data_sram_addr  = 32'h200;
        bus.data_sram_wdata = 32'h22222222;
        step();
        idle();
        check("coll_old", bus.inst_sram_rdata, 32'h11111111);
        iread(32'h200);
        check("coll_new", bus.inst_sram_rdata, 32'h22222222);
        step();
        check("inst_hold", bus.inst_sram_rdata, 32'h22222222);

        bus2.data_sram_en    = 1'b1;
        bus2.data_sram_wen   = 4'b1111;
        bus2.data_sram_addr  = 32'h04;
        bus2.data_sram_wdata = 32'h5A5A5A5A;
        step();
        idle();
        bus2.data_sram_en   = 1'b1;
        bus2.data_sram_addr = 32'h44;
        bus2.inst_sram_en   = 1'b1;
        bus2.inst_sram_addr = 32'h07;
        step();
        idle();
        check("alias_44", bus2.data_sram_rdata, 32'h5A5A5A5A);
        check("alias_07", bus2.inst_sram_rdata, 32'h5A5A5A5A);
        bus2.data_sram_en   = 1'b1;
        bus2.data_sram_addr = 32'h08;
        step();
        idle();
        check("alias_other", bus2.data_sram_rdata === 32'h5A5A5A5A, 32'h0);

`ifdef SRAM_PERF_CNT_EN
        cnt_clr = 1'b1;
        step();
        idle();
        check("clr_inst", inst_rd_cnt, 32'h0);
        for (int i = 0; i < 5; i++) iread(32'h100 + 32'(4*i));
        for (int i = 0; i < 3; i++) dread(32'h100);
        dwrite(32'h400, 32'h1, 4'b0001);
        dwrite(32'h404, 32'h2, 4'b0010);
        check("cnt_inst", inst_rd_cnt, 32'd5);
        check("cnt_drd", data_rd_cnt, 32'd3);
        check("cnt_dwr", data_wr_cnt, 32'd2);
        cnt_clr = 1'b1;
        dwrite(32'h408, 32'h3, 4'b1111);
        check("clr_wins", data_wr_cnt, 32'h0);
        force dut.inst_cnt_q = 32'hFFFFFFFF;
        #1;
        release dut.inst_cnt_q;
        iread(32'h100);
        check("cnt_sat", inst_rd_cnt, 32'hFFFFFFFF);
`else
        for (int i = 0; i < 2; i++) iread(32'h100);
        dwrite(32'h400, 32'h1, 4'b0001);
        cnt_clr = 1'b1;
        dread(32'h400);
        check("cnt_off_i", inst_rd_cnt, 32'h0);
        check("cnt_off_r", data_rd_cnt, 32'h0);
        check("cnt_off_w", data_wr_cnt, 32'h0);
`endif

        dwrite(32'h8, 32'hCAFEF00D, 4'b1111);
        iread(32'h200);
        dread(32'h100);
        check("pre_rst_d", bus.data_sram_rdata, 32'hDEADBEAA);
        bus.data_sram_en    = 1'b1;
        bus.data_sram_wen   = 4'b1111;
        bus.data_sram_addr  = 32'h8;
        bus.data_sram_wdata = 32'hFFFFFFFF;
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_i", bus.inst_sram_rdata, 32'h0);
        check("async_rst_d", bus.data_sram_rdata, 32'h0);
        check("async_rst_c", inst_rd_cnt, 32'h0);
        step();
        idle();
        reset = 1'b0;
        dread(32'h8);
        check("rst_no_wr", bus.data_sram_rdata, 32'hCAFEF00D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
